// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cooking sequencer.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEC_WRAP = 8'h59;

    // Two-digit BCD decrement; callers never pass 8'h00.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// Four-digit MM:SS BCD register: keypad shift-in, clear and one-second decrement.
module mmss_down_counter
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  bcd_t       digit,
    input  logic       dec,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       zero_next
);

    logic [15:0] mmss_r;

    assign mm        = mmss_r[15:8];
    assign ss        = mmss_r[7:0];
    assign zero_next = (mmss_r[15:8] == 8'h00) && (mmss_r[7:0] == 8'h01);

    // Time register: clear wins over keypad shift, shift over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmss_r <= 16'h0000;
        end else if (clr) begin
            mmss_r <= 16'h0000;
        end else if (shift_en) begin
            mmss_r <= {mmss_r[11:0], digit};
        end else if (dec) begin
            // Seconds are not normalised, so 75 counts down through BCD before wrapping.
            if (mmss_r[7:0] != 8'h00) begin
                mmss_r <= {mmss_r[15:8], bcd2_dec(mmss_r[7:0])};
            end else begin
                mmss_r <= {bcd2_dec(mmss_r[15:8]), SEC_WRAP};
            end
        end else begin
            mmss_r <= mmss_r;
        end
    end

endmodule

// File: rtl/microwave_sequencer.sv
// Cooking sequencer: keypad entry, start/stop/clear handling, door pause and
// MM:SS countdown driving the magnetron enable.
module microwave_sequencer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       mag_on,
    output logic [7:0] time_mm,
    output logic [7:0] time_ss,
    output logic       done,
    output logic [2:0] state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic          startn_prev_r;
    logic          mag_on_r, done_r;
    logic          start_ev_s, stop_s, clear_s, digit_ok_s, tick_s, time_zero_s;
    logic          cnt_clr_s, cnt_shift_s, cnt_dec_s, zero_next_s;
    logic [7:0]    mm_s, ss_s;

    assign start_ev_s  = startn_prev_r & ~startn;
    assign stop_s      = ~stopn;
    assign clear_s     = ~clearn;
    assign digit_ok_s  = digit_valid && (digit <= 4'd9);
    assign tick_s      = (presc_r == PRESC_LAST);
    assign time_zero_s = (mm_s == 8'h00) && (ss_s == 8'h00);

    mmss_down_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr_s),
        .shift_en  (cnt_shift_s),
        .digit     (digit),
        .dec       (cnt_dec_s),
        .mm        (mm_s),
        .ss        (ss_s),
        .zero_next (zero_next_s)
    );

    // Next-state, prescaler and counter controls; branch order encodes event priority.
    always_comb begin
        state_s     = state_r;
        presc_s     = presc_r;
        cnt_clr_s   = 1'b0;
        cnt_shift_s = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                presc_s = '0;
                if (clear_s || stop_s) begin
                    cnt_clr_s = 1'b1;
                end else if (digit_ok_s) begin
                    cnt_shift_s = 1'b1;
                    state_s     = SET;
                end else begin
                    state_s = IDLE;
                end
            end
            SET: begin
                presc_s = '0;
                if (clear_s || stop_s) begin
                    cnt_clr_s = 1'b1;
                    state_s   = IDLE;
                end else if (start_ev_s) begin
                    if (door_closed && !time_zero_s) begin
                        state_s = COOK;
                    end else begin
                        state_s = SET;
                    end
                end else if (digit_ok_s) begin
                    cnt_shift_s = 1'b1;
                end else begin
                    state_s = SET;
                end
            end
            COOK: begin
                if (clear_s) begin
                    cnt_clr_s = 1'b1;
                    presc_s   = '0;
                    state_s   = IDLE;
                end else if (stop_s || !door_closed) begin
                    // Prescaler is frozen so the interrupted second resumes where it left off.
                    state_s = PAUSE;
                end else if (tick_s) begin
                    cnt_dec_s = 1'b1;
                    presc_s   = '0;
                    if (zero_next_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = COOK;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            PAUSE: begin
                if (clear_s || stop_s) begin
                    cnt_clr_s = 1'b1;
                    presc_s   = '0;
                    state_s   = IDLE;
                end else if (start_ev_s && door_closed) begin
                    state_s = COOK;
                end else begin
                    state_s = PAUSE;
                end
            end
            DONE: begin
                presc_s = '0;
                if (clear_s || stop_s || start_ev_s || !door_closed) begin
                    cnt_clr_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                presc_s   = '0;
                state_s   = IDLE;
            end
        endcase
    end

    // State, prescaler, start-edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            presc_r       <= '0;
            startn_prev_r <= 1'b1;
            mag_on_r      <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            presc_r       <= presc_s;
            startn_prev_r <= startn;
            mag_on_r      <= (state_s == COOK);
            done_r        <= (state_s == DONE);
        end
    end

    assign mag_on  = mag_on_r;
    assign done    = done_r;
    assign state   = state_r;
    assign time_mm = mm_s;
    assign time_ss = ss_s;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer with TICKS_PER_SEC = 4.
module tb_microwave_sequencer;
    import microwave_pkg::*;

    logic       clk = 1'b0;
    logic       rst, startn, stopn, clearn, door_closed, digit_valid;
    logic [3:0] digit;
    logic       mag_on, done;
    logic [7:0] time_mm, time_ss;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst, startn, stopn, clearn, door, dv;
        logic [3:0] dg;
        logic [2:0] st;
        logic       mag;
        logic [7:0] mm, ss;
        logic       dn;
    } vec_t;

    vec_t vq[$];

    microwave_sequencer #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .digit_valid(digit_valid), .digit(digit),
        .mag_on(mag_on), .time_mm(time_mm), .time_ss(time_ss), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, sn, pn, cn, dr, dv, input logic [3:0] dg,
                       input logic [2:0] st, input logic mg, input logic [7:0] mm, ss,
                       input logic dn);
        vec_t v;
        v.rst = r; v.startn = sn; v.stopn = pn; v.clearn = cn; v.door = dr; v.dv = dv;
        v.dg = dg; v.st = st; v.mag = mg; v.mm = mm; v.ss = ss; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] es, input logic em,
                         input logic [7:0] emm, ess, input logic ed);
        n_cmp++;
        if ({state, mag_on, time_mm, time_ss, done} !== {es, em, emm, ess, ed}) begin
            n_err++;
            $display("FAIL %s: got st=%0d mag=%b %h:%h done=%b, want st=%0d mag=%b %h:%h done=%b",
                     nm, state, mag_on, time_mm, time_ss, done, es, em, emm, ess, ed);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; digit_valid = 1'b0; digit = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1; digit = d;
        step(1);
        digit_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] ess;
        idle_inputs();

        // Basic 3-second cook plus entry edge cases, one row per clock.
        add(1,1,1,1,1,0,4'h0, IDLE, 0,8'h00,8'h00,0);
        add(0,1,1,1,1,1,4'h0, SET,  0,8'h00,8'h00,0);
        add(0,1,1,1,1,1,4'h0, SET,  0,8'h00,8'h00,0);
        add(0,0,1,1,1,0,4'h0, SET,  0,8'h00,8'h00,0);
        add(0,1,1,1,1,1,4'h0, SET,  0,8'h00,8'h00,0);
        add(0,1,1,1,1,1,4'hA, SET,  0,8'h00,8'h00,0);
        add(0,1,1,1,1,1,4'h3, SET,  0,8'h00,8'h03,0);
        add(0,0,1,1,1,0,4'h0, COOK, 1,8'h00,8'h03,0);
        for (int s = 3; s >= 1; s--) begin
            for (int c = 0; c < 4; c++) begin
                ess = (c == 3) ? 8'(s - 1) : 8'(s);
                if (s == 1 && c == 3)
                    add(0,1,1,1,1,0,4'h0, DONE, 0,8'h00,8'h00,1);
                else
                    add(0,1,1,1,1,0,4'h0, COOK, 1,8'h00,ess,0);
            end
        end
        add(0,1,1,1,1,0,4'h0, DONE, 0,8'h00,8'h00,1);
        add(0,1,0,1,1,0,4'h0, IDLE, 0,8'h00,8'h00,0);
        add(0,1,0,1,1,1,4'h5, IDLE, 0,8'h00,8'h00,0);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; startn = vq[i].startn; stopn = vq[i].stopn;
            clearn = vq[i].clearn; door_closed = vq[i].door;
            digit_valid = vq[i].dv; digit = vq[i].dg;
            step(1);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].mag, vq[i].mm, vq[i].ss, vq[i].dn);
        end

        // Five digits keep the last four; held start gives one start event; priority.
        do_reset();
        check("reset_state", IDLE, 0, 8'h00, 8'h00, 0);
        for (int d = 1; d <= 5; d++) key(4'(d));
        check("five_digits", SET, 0, 8'h23, 8'h45, 0);
        startn = 1'b0; step(1);
        check("held_start_cook", COOK, 1, 8'h23, 8'h45, 0);
        step(1);
        door_closed = 1'b0; step(1);
        check("held_start_door_pause", PAUSE, 0, 8'h23, 8'h45, 0);
        door_closed = 1'b1; step(1);
        check("held_start_no_restart", PAUSE, 0, 8'h23, 8'h45, 0);
        startn = 1'b1; step(1);
        startn = 1'b0; step(1);
        check("new_press_resumes", COOK, 1, 8'h23, 8'h45, 0);
        startn = 1'b1; clearn = 1'b0; stopn = 1'b0; door_closed = 1'b0; step(1);
        check("priority_clear", IDLE, 0, 8'h00, 8'h00, 0);

        // Seconds wrap and a full 60-second cook.
        do_reset();
        key(4'h1); key(4'h0); key(4'h0);
        check("enter_0100", SET, 0, 8'h01, 8'h00, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        check("wrap_start", COOK, 1, 8'h01, 8'h00, 0);
        step(3);
        check("wrap_before_tick", COOK, 1, 8'h01, 8'h00, 0);
        step(1);
        check("wrap_to_0059", COOK, 1, 8'h00, 8'h59, 0);
        cyc = 4;
        while (done !== 1'b1 && cyc < 300) begin
            step(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 240) begin
            n_err++;
            $display("FAIL wrap_cook_len: got %0d cycles, want 240", cyc);
        end
        check("wrap_done", DONE, 0, 8'h00, 8'h00, 1);

        // Door pause at prescaler offset 2, start ignored with door open, resume.
        do_reset();
        key(4'h5);
        startn = 1'b0; step(1); startn = 1'b1;
        check("pause_start", COOK, 1, 8'h00, 8'h05, 0);
        step(2);
        check("pause_pre", COOK, 1, 8'h00, 8'h05, 0);
        door_closed = 1'b0; step(1);
        check("pause_door_open", PAUSE, 0, 8'h00, 8'h05, 0);
        startn = 1'b0; step(1);
        check("pause_start_door_open", PAUSE, 0, 8'h00, 8'h05, 0);
        startn = 1'b1; step(1);
        door_closed = 1'b1; step(1);
        check("pause_door_closed", PAUSE, 0, 8'h00, 8'h05, 0);
        startn = 1'b0; step(1); startn = 1'b1;
        check("pause_resume", COOK, 1, 8'h00, 8'h05, 0);
        step(1);
        check("pause_resume_1", COOK, 1, 8'h00, 8'h05, 0);
        step(1);
        check("pause_resume_tick", COOK, 1, 8'h00, 8'h04, 0);

        // Reset mid-cook overrides a simultaneous start press.
        rst = 1'b1; startn = 1'b0; step(1);
        check("reset_mid_cook", IDLE, 0, 8'h00, 8'h00, 0);
        idle_inputs(); step(1);
        check("after_reset", IDLE, 0, 8'h00, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
